ads131_spi_target: RTL and testbench



---
 rtl/ads131_tgt_pkg.sv | 17 +
 rtl/spi_tgt_sync_edge.sv | 50 +++++
 rtl/ads131_spi_target.sv | 185 ++++++++++++++++++
 tb/tb_ads131_spi_target.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ads131_tgt_pkg.sv
// Shared constants for the ADS131E08-style SPI target: opcode prefixes,
// FSM state encoding and the ID register address.
package ads131_tgt_pkg;

    localparam logic [2:0] OPC_RREG = 3'b001;
    localparam logic [2:0] OPC_WREG = 3'b010;
    localparam logic [5:0] ID_ADDR  = 6'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPC   = 3'd1,
        ST_CNT   = 3'd2,
        ST_RDATA = 3'd3,
        ST_WDATA = 3'd4
    } state_e;

endpackage

// File: rtl/spi_tgt_sync_edge.sv
// Two-flop synchronizers for the SPI pins with SCK rise/fall and CS fall
// detection; MOSI is delayed to stay aligned with the SCK edge pulses.
module spi_tgt_sync_edge (
    input  logic I_clk,
    input  logic I_rst_n,
    input  logic I_sck,
    input  logic I_cs,
    input  logic I_mosi,
    output logic O_sck_rise,
    output logic O_sck_fall,
    output logic O_cs_lvl,
    output logic O_cs_fall,
    output logic O_mosi
);

    logic [2:0] sck_q, sck_d;
    logic [2:0] cs_q, cs_d;
    logic [1:0] mosi_q, mosi_d;
    logic [2:0] fill_q, fill_d;

    always_comb begin
        sck_d  = {sck_q[1:0], I_sck};
        cs_d   = {cs_q[1:0], I_cs};
        mosi_d = {mosi_q[0], I_mosi};
        fill_d = {fill_q[1:0], 1'b1};
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            sck_q  <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
            fill_q <= 3'b000;
        end else begin
            sck_q  <= sck_d;
            cs_q   <= cs_d;
            mosi_q <= mosi_d;
            fill_q <= fill_d;
        end
    end

    assign O_sck_rise = sck_q[1] & ~sck_q[2];
    assign O_sck_fall = ~sck_q[1] & sck_q[2];
    assign O_cs_lvl   = cs_q[1];
    // A CS fall only counts once the chain holds real samples, so a CS held
    // low through reset release does not open a frame.
    assign O_cs_fall  = fill_q[2] & cs_q[2] & ~cs_q[1];
    assign O_mosi     = mosi_q[1];

endmodule

// File: rtl/ads131_spi_target.sv
// ADS131E08-style SPI target: RREG/WREG/single-byte command decode, register
// file and MISO driver. Define ADS131_TGT_ID_RO_EN to make the ID register read-only.
module ads131_spi_target
    import ads131_tgt_pkg::*;
#(
    parameter int         REG_COUNT = 26,
    parameter logic [7:0] ID_VALUE  = 8'hD2
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_spi_sck,
    input  logic       I_spi_cs,
    input  logic       I_spi_mosi,
    output logic       O_spi_miso,
    output logic       O_cmd_valid,
    output logic [7:0] O_cmd,
    output logic       O_wr_valid,
    output logic [4:0] O_wr_addr,
    output logic [7:0] O_wr_data,
    output logic       O_busy
);

    logic sck_rise, sck_fall, cs_lvl, cs_fall, mosi_s;

    spi_tgt_sync_edge u_sync (
        .I_clk      (I_clk),
        .I_rst_n    (I_rst_n),
        .I_sck      (I_spi_sck),
        .I_cs       (I_spi_cs),
        .I_mosi     (I_spi_mosi),
        .O_sck_rise (sck_rise),
        .O_sck_fall (sck_fall),
        .O_cs_lvl   (cs_lvl),
        .O_cs_fall  (cs_fall),
        .O_mosi     (mosi_s)
    );

    state_e     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;
    logic [5:0] addr_q, addr_d;
    logic [4:0] remain_q, remain_d;
    logic       is_rd_q, is_rd_d;
    logic [7:0] miso_sh_q, miso_sh_d;
    logic [7:0] cmd_q, cmd_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       wr_valid_q, wr_valid_d;
    logic [4:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] regs_q [REG_COUNT];
    logic [7:0] regs_d [REG_COUNT];

    logic [7:0] rx_byte;
    logic [7:0] rd_byte;
    logic       wr_ok;

    assign rx_byte = {shift_q[6:0], mosi_s};

`ifdef ADS131_TGT_ID_RO_EN
    assign wr_ok = (addr_q < 6'(REG_COUNT)) && (addr_q != ID_ADDR);
`else
    assign wr_ok = (addr_q < 6'(REG_COUNT));
`endif

    // Addresses past the implemented range read back as zero.
    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (addr_q == 6'(i)) rd_byte = regs_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        is_rd_d     = is_rd_q;
        miso_sh_d   = miso_sh_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;

        if (state_q != ST_RDATA) miso_sh_d = 8'h00;

        if (cs_lvl) begin
            state_d  = ST_IDLE;
            bitcnt_d = 3'd0;
            shift_d  = 8'h00;
        end else if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                state_d  = ST_OPC;
                bitcnt_d = 3'd0;
                shift_d  = 8'h00;
            end
        end else begin
            if (sck_rise && state_q == ST_RDATA) begin
                miso_sh_d = (bitcnt_q == 3'd0) ? rd_byte : {miso_sh_q[6:0], 1'b0};
            end
            if (sck_fall) begin
                bitcnt_d = bitcnt_q + 3'd1;
                shift_d  = rx_byte;
                if (bitcnt_q == 3'd7) begin
                    case (state_q)
                        ST_OPC: begin
                            if (rx_byte[7:5] == OPC_RREG || rx_byte[7:5] == OPC_WREG) begin
                                addr_d  = {1'b0, rx_byte[4:0]};
                                is_rd_d = (rx_byte[7:5] == OPC_RREG);
                                state_d = ST_CNT;
                            end else begin
                                cmd_d       = rx_byte;
                                cmd_valid_d = 1'b1;
                            end
                        end
                        ST_CNT: begin
                            remain_d = rx_byte[4:0];
                            state_d  = is_rd_q ? ST_RDATA : ST_WDATA;
                        end
                        ST_RDATA, ST_WDATA: begin
                            if (state_q == ST_WDATA && wr_ok) begin
                                for (int i = 0; i < REG_COUNT; i++) begin
                                    if (addr_q == 6'(i)) regs_d[i] = rx_byte;
                                end
                                wr_valid_d = 1'b1;
                                wr_addr_d  = addr_q[4:0];
                                wr_data_d  = rx_byte;
                            end
                            addr_d = addr_q + 6'd1;
                            if (remain_q == 5'd0) state_d = ST_OPC;
                            else                  remain_d = remain_q - 5'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            addr_q      <= 6'd0;
            remain_q    <= 5'd0;
            is_rd_q     <= 1'b0;
            miso_sh_q   <= 8'h00;
            cmd_q       <= 8'h00;
            cmd_valid_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 8'h00;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= (i == 0) ? ID_VALUE : 8'h00;
            end
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            is_rd_q     <= is_rd_d;
            miso_sh_q   <= miso_sh_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    assign O_spi_miso  = miso_sh_q[7] & (state_q == ST_RDATA);
    assign O_cmd_valid = cmd_valid_q;
    assign O_cmd       = cmd_q;
    assign O_wr_valid  = wr_valid_q;
    assign O_wr_addr   = wr_addr_q;
    assign O_wr_data   = wr_data_q;
    assign O_busy      = ~cs_lvl;

endmodule

// File: tb/tb_ads131_spi_target.sv
// Directed bench for ads131_spi_target: drives SPI frames with a slow SCK and
// checks MISO bytes and the command/write pulse streams against hand-computed values.
module tb_ads131_spi_target;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       cmd_valid;
    logic [7:0] cmd;
    logic       wr_valid;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    ads131_spi_target dut (
        .I_clk       (clk),
        .I_rst_n     (rst_n),
        .I_spi_sck   (sck),
        .I_spi_cs    (cs),
        .I_spi_mosi  (mosi),
        .O_spi_miso  (miso),
        .O_cmd_valid (cmd_valid),
        .O_cmd       (cmd),
        .O_wr_valid  (wr_valid),
        .O_wr_addr   (wr_addr),
        .O_wr_data   (wr_data),
        .O_busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int cmd_cnt = 0;
    logic [7:0] cmd_log[$];
    logic [4:0] wa_log[$];
    logic [7:0] wd_log[$];

    // Every high cycle is logged, so a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            wa_log.push_back(wr_addr);
            wd_log.push_back(wr_data);
        end
        if (cmd_valid) begin
            cmd_cnt++;
            cmd_log.push_back(cmd);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            sck  = 1'b1;
            wait_clk(6);
            rx[i] = miso;
            sck  = 1'b0;
            wait_clk(6);
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_high();
        wait_clk(6);
        cs = 1'b1;
        wait_clk(8);
    endtask

    logic [7:0] rx;
    logic [7:0] id_exp;
    int         wr_exp;

    initial begin
`ifdef ADS131_TGT_ID_RO_EN
        id_exp = 8'hD2;
        wr_exp = 5;
`else
        id_exp = 8'h55;
        wr_exp = 6;
`endif
        wait_clk(4);
        check("rst_miso", miso, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd", cmd, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        wait_clk(5);

        // RREG of the ID register
        cs_low();
        check("busy_frame", busy, 1);
        xfer(8'h20, 8, rx); check("miso_opc_zero", rx, 8'h00);
        xfer(8'h00, 8, rx);
        xfer(8'h00, 8, rx); check("rd_id", rx, 8'hD2);
        cs_high();
        check("busy_idle", busy, 0);

        // WREG burst 1..3, then read back
        cs_low();
        xfer(8'h41, 8, rx); xfer(8'h02, 8, rx);
        xfer(8'h11, 8, rx); xfer(8'h22, 8, rx); xfer(8'h33, 8, rx);
        cs_high();
        check("wr_cnt3", wr_cnt, 3);
        check("wa0", wa_log[0], 1); check("wd0", wd_log[0], 8'h11);
        check("wa1", wa_log[1], 2); check("wd1", wd_log[1], 8'h22);
        check("wa2", wa_log[2], 3); check("wd2", wd_log[2], 8'h33);
        check("wr_addr_hold", wr_addr, 3);
        check("wr_data_hold", wr_data, 8'h33);
        cs_low();
        xfer(8'h21, 8, rx); xfer(8'h02, 8, rx);
        xfer(8'h00, 8, rx); check("rd_r1", rx, 8'h11);
        xfer(8'h00, 8, rx); check("rd_r2", rx, 8'h22);
        xfer(8'h00, 8, rx); check("rd_r3", rx, 8'h33);
        cs_high();

        // Top of range: write 24/25, read 24..27, write beyond range
        cs_low();
        xfer(8'h58, 8, rx); xfer(8'h01, 8, rx);
        xfer(8'hA5, 8, rx); xfer(8'h5A, 8, rx);
        xfer(8'h38, 8, rx); xfer(8'h03, 8, rx);
        xfer(8'h00, 8, rx); check("rd_r24", rx, 8'hA5);
        xfer(8'h00, 8, rx); check("rd_r25", rx, 8'h5A);
        xfer(8'h00, 8, rx); check("rd_r26", rx, 8'h00);
        xfer(8'h00, 8, rx); check("rd_r27", rx, 8'h00);
        xfer(8'h5F, 8, rx); xfer(8'h00, 8, rx); xfer(8'hAA, 8, rx);
        cs_high();
        check("wr_cnt_oor", wr_cnt, 5);

        // Single-byte commands
        cs_low();
        xfer(8'h11, 8, rx); xfer(8'h08, 8, rx);
        cs_high();
        check("cmd_cnt", cmd_cnt, 2);
        check("cmd0", cmd_log[0], 8'h11);
        check("cmd1", cmd_log[1], 8'h08);
        check("cmd_hold", cmd, 8'h08);
        check("wr_cnt_cmd", wr_cnt, 5);

        // Abort a WREG data byte after 5 bits
        cs_low();
        xfer(8'h43, 8, rx); xfer(8'h00, 8, rx); xfer(8'hFF, 5, rx);
        cs_high();
        check("wr_cnt_abort", wr_cnt, 5);
        cs_low();
        xfer(8'h23, 8, rx); xfer(8'h00, 8, rx);
        xfer(8'h00, 8, rx); check("rd_r3_kept", rx, 8'h33);
        cs_high();

        // Write ID then read it back in the same frame
        cs_low();
        xfer(8'h40, 8, rx); xfer(8'h00, 8, rx); xfer(8'h55, 8, rx);
        xfer(8'h20, 8, rx); xfer(8'h00, 8, rx);
        xfer(8'h00, 8, rx); check("rd_id_after_wr", rx, id_exp);
        cs_high();
        check("wr_cnt_id", wr_cnt, wr_exp);

        // Reset in the middle of a frame with CS still low
        cs_low();
        xfer(8'h41, 8, rx); xfer(8'h00, 8, rx); xfer(8'hFF, 4, rx);
        rst_n = 1'b0;
        wait_clk(3);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd", cmd, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        rst_n = 1'b1;
        wait_clk(6);
        xfer(8'h20, 8, rx); xfer(8'h00, 8, rx);
        xfer(8'h00, 8, rx); check("no_frame_after_rst", rx, 8'h00);
        cs_high();
        check("cmd_cnt_rst", cmd_cnt, 2);
        cs_low();
        xfer(8'h21, 8, rx); xfer(8'h00, 8, rx);
        xfer(8'h00, 8, rx); check("rd_r1_reset", rx, 8'h00);
        xfer(8'h20, 8, rx); xfer(8'h00, 8, rx);
        xfer(8'h00, 8, rx); check("rd_id_reset", rx, 8'hD2);
        cs_high();
        check("miso_idle", miso, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
